// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 front end.
//   XLEN          - architectural register / address width
//   NOP_ENC       - canonical NOP (addi x0,x0,0) driven when no instruction is held
//   fetch_state_t - fetch sequencer states
//   word_align()  - clears the byte-offset bits of an address
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_ENC = 32'h0000_0013;

  // REQ  : request on the bus, waiting for grant
  // WAIT : granted, waiting for read data to deliver
  // DROP : granted, read data will be thrown away (redirected meanwhile)
  // OUT  : instruction held on the IF outputs
  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2,
    FS_OUT  = 2'd3
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage with a single-outstanding-request memory port.
// Issues one read at a time, captures the returned word together with its
// PC, and presents it to IF/ID until the decoder accepts it or execute
// redirects the stream.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   StallF              : IF/ID cannot accept; hold the current instruction
//   PCSrcE, PCTargetE   : redirect request and target from execute
//   imem_req/addr       : request valid / word address
//   imem_gnt            : request accepted this cycle
//   imem_rvalid/rdata   : in-order read response
//   InstrF/PCF/PCPlus4F : fetched instruction, its address, address + 4
//   ValidF              : the three outputs above carry a real instruction
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_ENC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic            ValidF
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] pcp4_q, pcp4_d;
  logic            valid_q, valid_d;

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_inc;

  // Redirect targets are forced onto a word boundary; the low bits of
  // PCTargetE are deliberately dropped.
  assign target = word_align(PCTargetE);
  assign pc_inc = pc_q + 32'd4;  // wraps modulo 2^32 by construction

  logic unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^PCTargetE[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcf_d   = pcf_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;

    unique case (state_q)
      FS_REQ: begin
        // rvalid here can only be a leftover from before a reset; ignore it.
        if (PCSrcE) pc_d = target;
        if (imem_gnt) state_d = PCSrcE ? FS_DROP : FS_WAIT;
      end

      FS_WAIT: begin
        if (imem_rvalid) begin
          if (PCSrcE) begin
            // Data for the old path arrives together with the redirect:
            // discard it and go straight to fetching the target.
            state_d = FS_REQ;
            pc_d    = target;
          end else begin
            state_d = FS_OUT;
            instr_d = imem_rdata;
            pcf_d   = pc_q;
            pcp4_d  = pc_inc;
            valid_d = 1'b1;
          end
        end else if (PCSrcE) begin
          // Response still in flight; it must be swallowed in DROP.
          state_d = FS_DROP;
          pc_d    = target;
        end
      end

      FS_DROP: begin
        // Later redirects only retarget the PC; exit still waits for rvalid.
        if (PCSrcE) pc_d = target;
        if (imem_rvalid) state_d = FS_REQ;
      end

      FS_OUT: begin
        // Redirect beats stall: the held instruction is on the wrong path.
        if (PCSrcE) begin
          state_d = FS_REQ;
          pc_d    = target;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end else if (!StallF) begin
          state_d = FS_REQ;
          pc_d    = pc_inc;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end

      default: state_d = FS_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FS_REQ;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcf_q   <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcf_q   <= pcf_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  // Reset gates the request so nothing is issued while reset is held.
  assign imem_req  = (state_q == FS_REQ) && !reset;
  assign imem_addr = pc_q;

  assign InstrF   = instr_q;
  assign PCF      = pcf_q;
  assign PCPlus4F = pcp4_q;
  assign ValidF   = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallF = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] InstrF, PCF, PCPlus4F;
  logic        ValidF;

  fetch_unit dut (
    .clk(clk), .reset(reset), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb_q[$];

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    e.instr = mem_f(pc);
    sb_q.push_back(e);
  endtask

  // Memory responder: grant per gnt_en, read data rv_dly cycles after grant.
  int gnt_en = 1;
  int rv_dly = 1;
  int rv_cnt = 0;
  logic [31:0] rsp_data = '0;

  initial forever begin
    @(negedge clk);
    if (rv_cnt == 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = rsp_data;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    if (rv_cnt > 0) rv_cnt--;
    imem_gnt = (gnt_en != 0);
    if (imem_req && imem_gnt) begin
      rv_cnt   = rv_dly;
      rsp_data = mem_f(imem_addr);
    end
  end

  // Each tick samples 1ns after the edge; a rising ValidF pops the scoreboard.
  logic vprev = 1'b0;
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (ValidF && !vprev) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        chk("PCF", PCF, e.pc);
        chk("PCPlus4F", PCPlus4F, e.pc + 32'd4);
        chk("InstrF", InstrF, e.instr);
      end
    end
    if (!ValidF) chk("nop_when_invalid", InstrF, NOP);
    vprev = ValidF;
  endtask

  task automatic wait_valid(input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      tick();
      if (ValidF) break;
    end
    if (i == bound) chk("valid_timeout", {31'd0, ValidF}, 1);
  endtask

  initial begin
    // Reset state, request gated while reset is high
    tick();
    tick();
    chk("rst_req", {31'd0, imem_req}, 0);
    chk("rst_valid", {31'd0, ValidF}, 0);
    chk("rst_instr", InstrF, NOP);
    chk("rst_pcf", PCF, 0);
    chk("rst_pcp4", PCPlus4F, 0);
    reset = 1'b0;
    #1;

    // Back-to-back fetches, gnt tied high, rvalid one cycle after gnt
    for (int k = 0; k < 5; k++) begin
      logic [31:0] a;
      a = 32'(k * 4);
      chk("seq_req", {31'd0, imem_req}, 1);
      chk("seq_addr", imem_addr, a);
      push_exp(a);
      tick();
      tick();
      chk("seq_latency", {31'd0, ValidF}, 1);
      if (k < 4) tick();
    end

    // Stall four cycles in OUT at PCF=0x10
    StallF = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("stall_valid", {31'd0, ValidF}, 1);
      chk("stall_pcf", PCF, 32'h10);
      chk("stall_pcp4", PCPlus4F, 32'h14);
      chk("stall_req", {31'd0, imem_req}, 0);
      if (k < 3) tick();
    end
    StallF = 1'b0;
    tick();
    chk("post_stall_addr", imem_addr, 32'h14);
    chk("post_stall_req", {31'd0, imem_req}, 1);

    // Redirect while waiting; late response must be dropped
    rv_dly = 2;
    tick();
    PCSrcE = 1'b1;
    PCTargetE = 32'h100;
    tick();
    PCSrcE = 1'b0;
    tick();
    chk("drop_valid", {31'd0, ValidF}, 0);
    chk("drop_req", {31'd0, imem_req}, 1);
    chk("drop_addr", imem_addr, 32'h100);
    push_exp(32'h100);
    wait_valid(10);

    // Redirect beats stall in OUT; target realigned
    StallF = 1'b1;
    PCSrcE = 1'b1;
    PCTargetE = 32'h203;
    tick();
    StallF = 1'b0;
    PCSrcE = 1'b0;
    rv_dly = 1;
    chk("redir_out_valid", {31'd0, ValidF}, 0);
    chk("redir_out_addr", imem_addr, 32'h200);
    push_exp(32'h200);
    wait_valid(10);

    // Grant withheld: address stays put
    gnt_en = 0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("nognt_req", {31'd0, imem_req}, 1);
      chk("nognt_addr", imem_addr, 32'h204);
      tick();
    end
    // Redirect without grant, to the top word to exercise wrap
    PCSrcE = 1'b1;
    PCTargetE = 32'hFFFF_FFFC;
    tick();
    PCSrcE = 1'b0;
    gnt_en = 1;
    chk("nognt_redir_addr", imem_addr, 32'hFFFF_FFFC);
    push_exp(32'hFFFF_FFFC);
    wait_valid(10);
    chk("wrap_pcp4", PCPlus4F, 32'h0);
    tick();
    chk("wrap_next_addr", imem_addr, 32'h0);

    // Reset in WAIT; stale rvalid arrives in REQ and is ignored
    rv_dly = 2;
    tick();
    reset = 1'b1;
    #1;
    chk("rstw_req", {31'd0, imem_req}, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rstw_valid", {31'd0, ValidF}, 0);
    chk("rstw_instr", InstrF, NOP);
    chk("rstw_addr", imem_addr, 32'h0);
    chk("rstw_req2", {31'd0, imem_req}, 1);
    tick();
    chk("rstw_stale_ignored", {31'd0, ValidF}, 0);
    push_exp(32'h0);
    wait_valid(10);
    rv_dly = 1;

    // rvalid and redirect together in WAIT
    tick();
    chk("wr_addr", imem_addr, 32'h4);
    tick();
    PCSrcE = 1'b1;
    PCTargetE = 32'h300;
    tick();
    PCSrcE = 1'b0;
    chk("wr_valid", {31'd0, ValidF}, 0);
    chk("wr_addr2", imem_addr, 32'h300);
    push_exp(32'h300);
    wait_valid(10);

    tick();
    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, is the value driven on InstrF when no valid instruction is held.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 StallF  input  1  IF/ID cannot accept; hold the current instruction.
REQ-006 PCSrcE  input  1  redirect request from execute stage.
REQ-007 PCTargetE  input  32  redirect target address.
REQ-008 imem_req  output  1  instruction-memory request valid.
REQ-009 imem_addr  output  32  request word address.
REQ-010 imem_gnt  input  1  request accepted this cycle when imem_req=1.
REQ-011 imem_rvalid  input  1  read data valid.
REQ-012 imem_rdata  input  32  read data.
REQ-013 InstrF  output  32  fetched instruction toward IF/ID.
REQ-014 PCF  output  32  address of InstrF.
REQ-015 PCPlus4F  output  32  PCF+4.
REQ-016 ValidF  output  1  InstrF/PCF/PCPlus4F hold a valid instruction.

Function
REQ-017 The block SHALL keep at most one imem request outstanding; responses return in order.
REQ-018 The block SHALL hold fetch PC pc_q and a state among REQ, WAIT, DROP, OUT.
REQ-019 In REQ: imem_req=1, imem_addr=pc_q; in every other state imem_req=0.
REQ-020 REQ: gnt&!PCSrcE -> WAIT; gnt&PCSrcE -> DROP with pc_q<=target; !gnt&PCSrcE -> REQ with pc_q<=target; otherwise stay.
REQ-021 WAIT: rvalid&!PCSrcE -> OUT, capturing InstrF<=imem_rdata, PCF<=pc_q, PCPlus4F<=pc_q+4, ValidF<=1.
REQ-022 WAIT: rvalid&PCSrcE -> REQ, data discarded, pc_q<=target; !rvalid&PCSrcE -> DROP, pc_q<=target.
REQ-023 DROP: rvalid -> REQ, data discarded; PCSrcE in DROP updates pc_q<=target and does not change the state transition.
REQ-024 OUT: PCSrcE -> REQ, ValidF<=0, pc_q<=target (redirect wins over stall); else !StallF -> REQ, ValidF<=0, pc_q<=pc_q+4; else hold all outputs unchanged.
REQ-025 Redirect target SHALL be word-aligned: pc_q<={PCTargetE[31:2],2'b00}.
REQ-026 pc_q+4 and PCPlus4F SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-027 imem_rvalid in REQ or OUT SHALL be ignored; imem_gnt outside REQ SHALL be ignored.
REQ-028 Whenever ValidF=0, InstrF SHALL equal NOP_INSTR.
REQ-029 Minimum latency: imem_req at cycle N, gnt at N, rvalid at N+1 -> ValidF=1 at N+2; steady-state throughput one instruction per 3 cycles.
REQ-030 imem_addr SHALL remain stable while imem_req=1 and imem_gnt=0 unless PCSrcE.

Reset
REQ-031 On reset: state<=REQ, pc_q<=RESET_PC, ValidF<=0, InstrF<=NOP_INSTR, PCF<=0, PCPlus4F<=0.
REQ-032 imem_req SHALL be 0 while reset=1; first request issues the cycle after reset deasserts.
REQ-033 Reset during WAIT or DROP abandons the outstanding request; a late rvalid after reset arrives in REQ and is ignored.

Structure
REQ-034 Shared package riscv_pkg SHALL hold fetch_state_t enum, XLEN=32 and the NOP encoding constant.
REQ-035 Single module, no sub-module; next-state logic and registers in one file.

Verification
REQ-036 Reset, gnt tied 1, rvalid one cycle after gnt, StallF=0 -> imem_addr 0,4,8; ValidF pulses with PCF 0,4,8, PCPlus4F 4,8,12.
REQ-037 StallF=1 for 4 cycles in OUT at PCF=0x10 -> outputs hold 0x10 for all 4 cycles, no imem_req; next request addr 0x14.
REQ-038 PCSrcE=1, PCTargetE=0x100 in WAIT, rvalid 2 cycles later -> response discarded, ValidF stays 0, next imem_addr 0x100.
REQ-039 PCSrcE=1, PCTargetE=0x203 with StallF=1 in OUT -> ValidF<=0, next imem_addr 0x200.
REQ-040 gnt held 0 for 5 cycles -> imem_addr constant; RESET_PC=0xFFFF_FFFC -> PCPlus4F=0, next addr 0.
REQ-041 Reset asserted in WAIT, rvalid arrives next cycle -> ValidF=0, InstrF=NOP_INSTR, next addr RESET_PC.
